// File: rtl/lightsaber_length_ctrl_pkg.sv
// Shared types and helpers for the lightsaber blade-length controller.
package lsl_pkg;

    localparam int LSL_STATE_W     = 2;
    localparam int LSL_DEC_MAX_DEF = 99;
    localparam int LSL_MAX_INT_DEF = 3;

    typedef enum logic [LSL_STATE_W-1:0] {
        LSL_OFF = 2'd0,
        LSL_EXT = 2'd1,
        LSL_ON  = 2'd2,
        LSL_RET = 2'd3
    } lsl_state_e;

    // Compare two (int, dec) lengths: -1 if a<b, 0 if equal, +1 if a>b.
    function automatic int lsl_len_cmp(input int unsigned a_int, input int unsigned a_dec,
                                       input int unsigned b_int, input int unsigned b_dec);
        if (a_int != b_int) return (a_int > b_int) ? 1 : -1;
        if (a_dec != b_dec) return (a_dec > b_dec) ? 1 : -1;
        return 0;
    endfunction

endpackage

// File: rtl/lightsaber_length_ctrl_if.sv
// Target-length load handshake between the command/ALU path and the controller.
interface lightsaber_length_ctrl_if #(
    parameter int INT_W = 2,
    parameter int DEC_W = 7
);
    logic             load_vld;
    logic             load_rdy;
    logic [INT_W-1:0] load_int;
    logic [DEC_W-1:0] load_dec;

    modport master (output load_vld, output load_int, output load_dec, input load_rdy);
    modport slave  (input load_vld, input load_int, input load_dec, output load_rdy);
endinterface

// File: rtl/lightsaber_length_ctrl_fix_step.sv
// Combinational saturating +/-STEP on an (int, dec) hundredths length.
// Extending clamps down to the bound, retracting clamps up to the bound
// (the bound is 0.00 when retracting).
module lsl_fix_step
    import lsl_pkg::*;
#(
    parameter int INT_W   = 2,
    parameter int DEC_W   = 7,
    parameter int DEC_MAX = LSL_DEC_MAX_DEF,
    parameter int STEP    = 5
) (
    input  logic             up,
    input  logic [INT_W-1:0] cur_int,
    input  logic [DEC_W-1:0] cur_dec,
    input  logic [INT_W-1:0] bnd_int,
    input  logic [DEC_W-1:0] bnd_dec,
    output logic [INT_W-1:0] res_int,
    output logic [DEC_W-1:0] res_dec
);

    // One extra bit on each field so carries and overshoot stay visible to the clamp.
    localparam logic [DEC_W:0] DMAX   = (DEC_W+1)'(DEC_MAX);
    localparam logic [DEC_W:0] DSTEP  = (DEC_W+1)'(STEP);
    localparam logic [DEC_W:0] DRADIX = (DEC_W+1)'(DEC_MAX + 1);

    logic [INT_W:0] raw_int;
    logic [DEC_W:0] raw_dec;
    logic [DEC_W:0] sum_dec;
    logic           clamp;

    // Step with carry/borrow across the decimal radix, then saturate at the bound.
    always_comb begin
        raw_int = {1'b0, cur_int};
        sum_dec = {1'b0, cur_dec} + DSTEP;
        raw_dec = sum_dec;
        clamp   = 1'b0;
        if (up) begin
            if (sum_dec > DMAX) begin
                raw_dec = sum_dec - DRADIX;
                raw_int = {1'b0, cur_int} + (INT_W+1)'(1);
            end
            clamp = (lsl_len_cmp(32'(raw_int), 32'(raw_dec), 32'(bnd_int), 32'(bnd_dec)) > 0);
        end else begin
            if ({1'b0, cur_dec} >= DSTEP) begin
                raw_dec = {1'b0, cur_dec} - DSTEP;
            end else if (cur_int == '0) begin
                clamp = 1'b1;   // would go below 0.00
            end else begin
                raw_int = {1'b0, cur_int} - (INT_W+1)'(1);
                raw_dec = {1'b0, cur_dec} + DRADIX - DSTEP;
            end
            clamp = clamp ||
                    (lsl_len_cmp(32'(raw_int), 32'(raw_dec), 32'(bnd_int), 32'(bnd_dec)) < 0);
        end
        res_int = clamp ? bnd_int : raw_int[INT_W-1:0];
        res_dec = clamp ? bnd_dec : raw_dec[DEC_W-1:0];
    end

endmodule

// File: rtl/lightsaber_length_ctrl.sv
// Lightsaber blade-length controller: holds a validated target length and
// animates the live length toward it (ignite) or toward 0.00 (retract).
// Optional feature macro LSL_TICK_DIV_EN: when defined, only every TICK_DIV-th
// tick seen while busy moves the blade; otherwise every tick is effective.
module lightsaber_length_ctrl
    import lsl_pkg::*;
#(
    parameter int INT_W    = 2,
    parameter int DEC_W    = 7,
    parameter int DEC_MAX  = LSL_DEC_MAX_DEF,
    parameter int MAX_INT  = LSL_MAX_INT_DEF,
    parameter int STEP     = 5,
    parameter int TICK_DIV = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    lightsaber_length_ctrl_if.slave ld,
    input  logic                   ignite,
    input  logic                   retract,
    input  logic                   tick,
    output logic [INT_W-1:0]       cur_int,
    output logic [DEC_W-1:0]       cur_dec,
    output logic [INT_W-1:0]       tgt_int,
    output logic [DEC_W-1:0]       tgt_dec,
    output logic [LSL_STATE_W-1:0] state,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    lsl_state_e       state_q, state_d;
    logic [INT_W-1:0] cur_int_d, tgt_int_d, step_int, bnd_int;
    logic [DEC_W-1:0] cur_dec_d, tgt_dec_d, step_dec, bnd_dec;
    logic             done_d, err_d;
    logic             eff_tick;
    logic             step_up;
    logic             load_ok;
    logic             tgt_nz;

    assign state       = state_q;
    assign busy        = (state_q == LSL_EXT) || (state_q == LSL_RET);
    assign ld.load_rdy = (state_q == LSL_OFF);

    assign load_ok = (32'(ld.load_int) <= 32'(MAX_INT)) && (32'(ld.load_dec) <= 32'(DEC_MAX));
    assign tgt_nz  = (lsl_len_cmp(32'(tgt_int), 32'(tgt_dec), 32'd0, 32'd0) > 0);

    // Single stepper shared by both directions; bound is tgt going up, 0.00 going down.
    assign step_up = (state_q != LSL_RET);
    assign bnd_int = step_up ? tgt_int : '0;
    assign bnd_dec = step_up ? tgt_dec : '0;

    lsl_fix_step #(
        .INT_W   (INT_W),
        .DEC_W   (DEC_W),
        .DEC_MAX (DEC_MAX),
        .STEP    (STEP)
    ) u_step (
        .up      (step_up),
        .cur_int (cur_int),
        .cur_dec (cur_dec),
        .bnd_int (bnd_int),
        .bnd_dec (bnd_dec),
        .res_int (step_int),
        .res_dec (step_dec)
    );

`ifdef LSL_TICK_DIV_EN
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;

    assign eff_tick = tick && busy && (pre_q == PRE_W'(TICK_DIV - 1));

    // Prescaler restarts on any state change so each new motion counts from zero.
    always_comb begin
        pre_d = pre_q;
        if (state_d != state_q)
            pre_d = '0;
        else if (tick && busy)
            pre_d = eff_tick ? '0 : pre_q + PRE_W'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pre_q <= '0;
        else     pre_q <= pre_d;
    end
`else
    localparam int unused_tick_div = TICK_DIV;

    assign eff_tick = tick && busy;
`endif

    // Next state, next lengths and status pulses.
    always_comb begin
        state_d   = state_q;
        cur_int_d = cur_int;
        cur_dec_d = cur_dec;
        tgt_int_d = tgt_int;
        tgt_dec_d = tgt_dec;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            LSL_OFF: begin
                if (ld.load_vld) begin
                    if (load_ok) begin
                        tgt_int_d = ld.load_int;
                        tgt_dec_d = ld.load_dec;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // retract is meaningless here; a zero target never ignites
                if (ignite && tgt_nz)
                    state_d = LSL_EXT;
            end
            LSL_EXT: begin
                if (retract) begin
                    state_d = LSL_RET;
                end else if (eff_tick) begin
                    cur_int_d = step_int;
                    cur_dec_d = step_dec;
                    if (lsl_len_cmp(32'(step_int), 32'(step_dec),
                                    32'(tgt_int), 32'(tgt_dec)) == 0) begin
                        state_d = LSL_ON;
                        done_d  = 1'b1;
                    end
                end
            end
            LSL_ON: begin
                if (retract)
                    state_d = LSL_RET;
            end
            LSL_RET: begin
                // retract wins a tie, so ignite alone reverses direction
                if (ignite && !retract) begin
                    state_d = LSL_EXT;
                end else if (eff_tick) begin
                    cur_int_d = step_int;
                    cur_dec_d = step_dec;
                    if (step_int == '0 && step_dec == '0) begin
                        state_d = LSL_OFF;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = LSL_OFF;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LSL_OFF;
            cur_int <= '0;
            cur_dec <= '0;
            tgt_int <= '0;
            tgt_dec <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_int <= cur_int_d;
            cur_dec <= cur_dec_d;
            tgt_int <= tgt_int_d;
            tgt_dec <= tgt_dec_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_lightsaber_length_ctrl.sv
// Directed bench for lightsaber_length_ctrl (STEP=5, DEC_MAX=99, MAX_INT=3).
// Lengths are checked as int*100+dec hundredths.
module tb_lightsaber_length_ctrl;

    localparam int INT_W = 2;
    localparam int DEC_W = 7;
`ifdef LSL_TICK_DIV_EN
    localparam int DIV = 4;
`else
    localparam int DIV = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ignite = 1'b0;
    logic             retract = 1'b0;
    logic             tick = 1'b0;
    logic [INT_W-1:0] cur_int, tgt_int;
    logic [DEC_W-1:0] cur_dec, tgt_dec;
    logic [1:0]       state;
    logic             busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    lightsaber_length_ctrl_if #(.INT_W(INT_W), .DEC_W(DEC_W)) ld_if ();

    always #5 clk = ~clk;

    lightsaber_length_ctrl #(
        .INT_W(INT_W), .DEC_W(DEC_W), .DEC_MAX(99), .MAX_INT(3), .STEP(5), .TICK_DIV(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld_if),
        .ignite  (ignite),
        .retract (retract),
        .tick    (tick),
        .cur_int (cur_int),
        .cur_dec (cur_dec),
        .tgt_int (tgt_int),
        .tgt_dec (tgt_dec),
        .state   (state),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    function automatic logic [31:0] cur_len();
        return 32'(cur_int) * 100 + 32'(cur_dec);
    endfunction

    function automatic logic [31:0] tgt_len();
        return 32'(tgt_int) * 100 + 32'(tgt_dec);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int li, input int lds);
        ld_if.load_vld = 1'b1;
        ld_if.load_int = INT_W'(li);
        ld_if.load_dec = DEC_W'(lds);
        cyc();
        ld_if.load_vld = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] mx;
        ld_if.load_vld = 1'b0;
        ld_if.load_int = '0;
        ld_if.load_dec = '0;

        // reset state
        cyc(); cyc();
        chk("rst_state", 32'(state), 0);
        chk("rst_cur", cur_len(), 0);
        chk("rst_tgt", tgt_len(), 0);
        chk("rst_rdy", 32'(ld_if.load_rdy), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        cyc();

        // ignite with zero target stays OFF
        ignite = 1'b1; cyc(); ignite = 1'b0;
        chk("zero_ign_state", 32'(state), 0);
        chk("zero_ign_done", 32'(done), 0);

        // load 1.20 and extend over 24 steps, carry at 0.95 -> 1.00
        load(1, 20);
        chk("ld120_tgt", tgt_len(), 120);
        chk("ld120_err", 32'(err), 0);
        ignite = 1'b1; cyc(); ignite = 1'b0;
        chk("ign_state", 32'(state), 1);
        chk("ign_busy", 32'(busy), 1);
        chk("ign_cur", cur_len(), 0);
        for (int i = 1; i <= 24 * DIV; i++) begin
            pulse_tick();
            chk("ext_cur", cur_len(), 32'(5 * (i / DIV)));
            chk("ext_done", 32'(done), 32'(i == 24 * DIV));
        end
        chk("ext_int", 32'(cur_int), 1);
        chk("ext_on", 32'(state), 2);
        cyc();
        chk("done_once", 32'(done), 0);
        ignite = 1'b1; cyc(); ignite = 1'b0;
        chk("on_ign_ignored", 32'(state), 2);

        // retract all the way
        retract = 1'b1; cyc(); retract = 1'b0;
        chk("ret_state", 32'(state), 3);
        n = 0;
        for (int i = 0; i < 400 && state != 2'd0; i++) begin
            pulse_tick();
            n++;
        end
        chk("ret_ticks", 32'(n), 32'(24 * DIV));
        chk("ret_cur", cur_len(), 0);
        chk("ret_done", 32'(done), 1);

        // load 2.03: last step clamps 2.00 -> 2.03
        load(2, 3);
        chk("ld203_tgt", tgt_len(), 203);
        ignite = 1'b1; cyc(); ignite = 1'b0;
        n = 0;
        mx = 0;
        for (int i = 0; i < 400 && state != 2'd2; i++) begin
            pulse_tick();
            n++;
            if (cur_len() > mx) mx = cur_len();
            if (n == 40 * DIV) chk("clamp_pre", cur_len(), 200);
        end
        chk("clamp_ticks", 32'(n), 32'(41 * DIV));
        chk("clamp_cur", cur_len(), 203);
        chk("clamp_max", mx, 203);
        chk("clamp_done", 32'(done), 1);

        // load while ON is ignored, no err
        chk("on_rdy", 32'(ld_if.load_rdy), 0);
        load(1, 0);
        chk("on_ld_tgt", tgt_len(), 203);
        chk("on_ld_err", 32'(err), 0);
        retract = 1'b1; cyc(); retract = 1'b0;
        for (int i = 0; i < 400 && state != 2'd0; i++) pulse_tick();
        chk("ret2_off", 32'(state), 0);

        // illegal then legal load at the upper boundary
        load(3, 100);
        chk("bad_err", 32'(err), 1);
        chk("bad_tgt", tgt_len(), 203);
        cyc();
        chk("bad_err_pulse", 32'(err), 0);
        load(3, 99);
        chk("max_tgt", tgt_len(), 399);
        chk("max_err", 32'(err), 0);

        // reversal at 0.40 with ignite+retract+tick together
        load(1, 0);
        ignite = 1'b1; cyc(); ignite = 1'b0;
        for (int i = 0; i < 8 * DIV; i++) pulse_tick();
        chk("rev_pre_cur", cur_len(), 40);
        ignite = 1'b1; retract = 1'b1; tick = 1'b1;
        cyc();
        ignite = 1'b0; retract = 1'b0; tick = 1'b0;
        chk("rev_state", 32'(state), 3);
        chk("rev_cur", cur_len(), 40);
        for (int i = 1; i <= 8 * DIV; i++) begin
            pulse_tick();
            chk("rev_down", cur_len(), 32'(40 - 5 * (i / DIV)));
        end
        chk("rev_off", 32'(state), 0);
        chk("rev_done", 32'(done), 1);
        pulse_tick();
        chk("off_tick_cur", cur_len(), 0);
        chk("off_tick_state", 32'(state), 0);

`ifdef LSL_TICK_DIV_EN
        // prescaled: only ticks 4 and 8 move the blade
        load(0, 10);
        ignite = 1'b1; cyc(); ignite = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            pulse_tick();
            chk("div_cur", cur_len(), (i >= 8) ? 10 : (i >= 4) ? 5 : 0);
            chk("div_state", 32'(state), (i == 8) ? 2 : 1);
        end
        retract = 1'b1; cyc(); retract = 1'b0;
        for (int i = 0; i < 100 && state != 2'd0; i++) pulse_tick();
`endif

        // asynchronous reset in the middle of extension at 1.35
        load(2, 0);
        ignite = 1'b1; cyc(); ignite = 1'b0;
        for (int i = 0; i < 27 * DIV; i++) pulse_tick();
        chk("mid_cur", cur_len(), 135);
        chk("mid_state", 32'(state), 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_cur", cur_len(), 0);
        chk("arst_tgt", tgt_len(), 0);
        chk("arst_rdy", 32'(ld_if.load_rdy), 1);
        chk("arst_busy", 32'(busy), 0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_state", 32'(state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
